lift_ctrl: RTL and testbench

LIFT_CTRL -- requirements
Module: lift_ctrl

---
 rtl/map_pkg.sv | 29 ++
 rtl/lift_ctrl_if.sv | 29 ++
 rtl/tick_gen.sv | 32 +++
 rtl/lift_ctrl.sv | 92 +++++++++
 tb/tb_lift_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// Shared map constants: lift FSM encodings, default lift geometry and the
// map pivot constants used by animated terrain objects.
// No ports; imported by lift_ctrl, lift_ctrl_if and related map blocks.
package map_pkg;

  // Pixel coordinate width (half-resolution rows/columns)
  localparam int unsigned PIX_W = 10;

  // Lift platform FSM encoding
  typedef enum logic [1:0] {
    LIFT_UP        = 2'd0,
    LIFT_MOVE_DOWN = 2'd1,
    LIFT_DOWN      = 2'd2,
    LIFT_MOVE_UP   = 2'd3
  } lift_state_e;

  // Default lift geometry
  localparam logic [PIX_W-1:0] LIFT_TOP_V    = 10'd96;
  localparam logic [PIX_W-1:0] LIFT_BOTTOM_V = 10'd130;
  localparam logic [PIX_W-1:0] LIFT_STEP     = 10'd1;

  // Map pivot constants shared by the moving-wall terrain instance
  localparam logic [PIX_W-1:0] MAP_PIVOT_H_DEFAULT = 10'd0;
  localparam logic [PIX_W-1:0] MAP_PIVOT_V_DEFAULT = LIFT_TOP_V;

  // Motion tick divider for 60 Hz at a 100 MHz clock
  localparam int unsigned TICK_DIV_60HZ = 1_666_667;

endpackage

// File: rtl/lift_ctrl_if.sv
// Lift controller signal bundle.
// Inputs to the lift: en, button1_touch, button2_touch, block_down.
// Outputs from the lift: pivot_v, moving, at_top, at_bottom, state.
interface lift_ctrl_if;
  import map_pkg::*;

  logic             en;
  logic             button1_touch;
  logic             button2_touch;
  logic             block_down;
  logic [PIX_W-1:0] pivot_v;
  logic             moving;
  logic             at_top;
  logic             at_bottom;
  logic [1:0]       state;

  // Game/player side drives controls and observes the platform
  modport master (
    output en, button1_touch, button2_touch, block_down,
    input  pivot_v, moving, at_top, at_bottom, state
  );

  // Lift controller side
  modport slave (
    input  en, button1_touch, button2_touch, block_down,
    output pivot_v, moving, at_top, at_bottom, state
  );

endinterface

// File: rtl/tick_gen.sv
// Motion tick divider, reusable by any animated map object.
// Ports: clk, rst (sync, active-high), en (freezes the count when low),
//        tick (one-cycle pulse on the cycle the counter wraps to 0).
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count 0..DIV-1 while enabled; tick marks the wrapping cycle
  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == CNT_W'(DIV - 1));
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lift_ctrl.sv
// Button-operated lift platform controller.
// Ports: clk, rst (sync, active-high), bus (lift_ctrl_if.slave):
//   en, button1_touch, button2_touch, block_down in;
//   pivot_v, moving, at_top, at_bottom, state out.
// State and pivot_v change only on motion ticks from tick_gen.
module lift_ctrl
  import map_pkg::*;
#(
  parameter logic [PIX_W-1:0] TOP_V    = LIFT_TOP_V,
  parameter logic [PIX_W-1:0] BOTTOM_V = LIFT_BOTTOM_V,
  parameter logic [PIX_W-1:0] STEP     = LIFT_STEP,
  parameter int unsigned      TICK_DIV = TICK_DIV_60HZ
) (
  input  logic        clk,
  input  logic        rst,
  lift_ctrl_if.slave  bus
);

  lift_state_e      state_q;
  lift_state_e      state_d;
  logic [PIX_W-1:0] pivot_q;
  logic [PIX_W-1:0] pivot_d;
  logic             tick;
  logic             req;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  // Next state / next pivot; distance checked before stepping so the
  // 10-bit arithmetic never wraps and the platform snaps to its end stop.
  always_comb begin
    state_d = state_q;
    pivot_d = pivot_q;
    req     = bus.button1_touch | bus.button2_touch;
    if (tick) begin
      case (state_q)
        LIFT_UP: begin
          if (req) state_d = LIFT_MOVE_DOWN;
        end
        LIFT_MOVE_DOWN: begin
          // Reversal wins over a blocked hold
          if (!req) begin
            state_d = LIFT_MOVE_UP;
          end else if (!bus.block_down) begin
            if ((BOTTOM_V - pivot_q) <= STEP) begin
              pivot_d = BOTTOM_V;
              state_d = LIFT_DOWN;
            end else begin
              pivot_d = pivot_q + STEP;
            end
          end
        end
        LIFT_DOWN: begin
          if (!req) state_d = LIFT_MOVE_UP;
        end
        LIFT_MOVE_UP: begin
          if (req) begin
            state_d = LIFT_MOVE_DOWN;
          end else if ((pivot_q - TOP_V) <= STEP) begin
            pivot_d = TOP_V;
            state_d = LIFT_UP;
          end else begin
            pivot_d = pivot_q - STEP;
          end
        end
        default: state_d = LIFT_UP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIFT_UP;
      pivot_q <= TOP_V;
    end else begin
      state_q <= state_d;
      pivot_q <= pivot_d;
    end
  end

  // Zero-latency status decodes of the registered state
  assign bus.pivot_v   = pivot_q;
  assign bus.state     = state_q;
  assign bus.moving    = (state_q == LIFT_MOVE_DOWN) || (state_q == LIFT_MOVE_UP);
  assign bus.at_top    = (pivot_q == TOP_V);
  assign bus.at_bottom = (pivot_q == BOTTOM_V);

endmodule

// File: tb/tb_lift_ctrl.sv
// Self-checking bench for lift_ctrl: directed scenarios followed by random
// button/block/enable/reset traffic, compared each cycle with a position
// and direction model of the lift.
module tb_lift_ctrl;

  localparam int unsigned DIV = 4;
  localparam int TOP = 96;
  localparam int BOT = 104;
  localparam int STP = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lift_ctrl_if lif ();

  lift_ctrl #(
    .TOP_V    (10'd96),
    .BOTTOM_V (10'd104),
    .STEP     (10'd3),
    .TICK_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif)
  );

  int checks   = 0;
  int failures = 0;

  // Model: position, whether travelling, travel direction, tick phase
  int m_pos   = TOP;
  int m_phase = 0;
  bit m_motion = 1'b0;
  bit m_down   = 1'b0;
  bit m_tick   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Encoding: resting at top/bottom = 0/2, travelling down/up = 1/3
  function automatic int m_state();
    if (m_motion) return m_down ? 1 : 3;
    return m_down ? 2 : 0;
  endfunction

  task automatic model_edge();
    bit req;
    m_tick = 1'b0;
    if (rst) begin
      m_pos = TOP; m_phase = 0; m_motion = 1'b0; m_down = 1'b0;
    end else if (lif.en) begin
      m_tick  = (m_phase == int'(DIV) - 1);
      m_phase = (m_phase + 1) % int'(DIV);
      if (m_tick) begin
        req = lif.button1_touch | lif.button2_touch;
        if (!m_motion) begin
          if (req != m_down) begin m_motion = 1'b1; m_down = req; end
        end else if (req != m_down) begin
          m_down = req;
        end else if (m_down) begin
          if (!lif.block_down) begin
            m_pos = (m_pos + STP > BOT) ? BOT : m_pos + STP;
            if (m_pos == BOT) m_motion = 1'b0;
          end
        end else begin
          m_pos = (m_pos - STP < TOP) ? TOP : m_pos - STP;
          if (m_pos == TOP) m_motion = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("pivot_v",   32'(lif.pivot_v),   m_pos);
    check_eq("state",     32'(lif.state),     m_state());
    check_eq("moving",    32'(lif.moving),    int'(m_motion));
    check_eq("at_top",    32'(lif.at_top),    int'(m_pos == TOP));
    check_eq("at_bottom", 32'(lif.at_bottom), int'(m_pos == BOT));
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      cyc();
      if (m_tick) seen++;
    end
    check_eq("tick_budget", 32'(seen), n);
  endtask

  task automatic expect_pv(input string tag, input int pv, input int st);
    check_eq({tag, "_pivot"}, 32'(lif.pivot_v), pv);
    check_eq({tag, "_state"}, 32'(lif.state), st);
  endtask

  initial begin
    rst = 1'b1;
    lif.en = 1'b1;
    lif.button1_touch = 1'b0;
    lif.button2_touch = 1'b0;
    lif.block_down = 1'b0;
    cyc();
    rst = 1'b0;
    expect_pv("reset", 96, 0);
    check_eq("reset_at_top", 32'(lif.at_top), 1);
    check_eq("reset_moving", 32'(lif.moving), 0);
    check_eq("reset_at_bottom", 32'(lif.at_bottom), 0);

    // Idle: lift rests at top
    for (int i = 0; i < 20; i++) cyc();
    expect_pv("idle", 96, 0);

    // Descend with button 1 held, snapping to the bottom
    lif.button1_touch = 1'b1;
    wait_ticks(1); expect_pv("start_down", 96, 1);
    wait_ticks(1); expect_pv("down1", 99, 1);
    wait_ticks(1); expect_pv("down2", 102, 1);
    wait_ticks(1); expect_pv("down_snap", 104, 2);
    check_eq("bottom_flag", 32'(lif.at_bottom), 1);

    // Release: climb back and snap to the top
    lif.button1_touch = 1'b0;
    wait_ticks(1); expect_pv("start_up", 104, 3);
    wait_ticks(1); expect_pv("up1", 101, 3);
    wait_ticks(1); expect_pv("up2", 98, 3);
    wait_ticks(1); expect_pv("up_snap", 96, 0);

    // Button 2 with block_down held at 99
    lif.button2_touch = 1'b1;
    wait_ticks(2); expect_pv("b2_down", 99, 1);
    lif.block_down = 1'b1;
    wait_ticks(3); expect_pv("blocked", 99, 1);
    lif.block_down = 1'b0;
    wait_ticks(1); expect_pv("unblocked", 102, 1);

    // Mid-descent release reverses without moving
    lif.button2_touch = 1'b0;
    wait_ticks(1); expect_pv("reverse", 102, 3);
    wait_ticks(1); expect_pv("reverse_step", 99, 3);

    // Re-press, freeze with en low, then reset mid-descent
    lif.button1_touch = 1'b1;
    wait_ticks(1); expect_pv("repress", 99, 1);
    lif.en = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    expect_pv("frozen", 99, 1);
    lif.en = 1'b1;
    wait_ticks(1); expect_pv("resume", 102, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_pv("mid_reset", 96, 0);
    lif.button1_touch = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  lif.button1_touch = ~lif.button1_touch;
      if ($urandom_range(15) == 0) lif.button2_touch = ~lif.button2_touch;
      if ($urandom_range(5) == 0)  lif.block_down = ~lif.block_down;
      lif.en = ($urandom_range(9) != 0);
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
